// File: rtl/mac_sub_job_sequencer.sv
// Job sequencer for a registered 20x18 multiply-subtract accumulator (acc = acc - a*b).
// A job is a command (init, length), a stream of operand pairs, a pipeline drain, then one result.
module mac_sub_job_sequencer #(
  parameter int A_W   = 20,
  parameter int B_W   = 18,
  parameter int ACC_W = 38,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [ACC_W-1:0] cmd_init,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [A_W-1:0]   op_a,
  input  logic [B_W-1:0]   op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic             r_s1_vld;
  logic [CNT_W-1:0] r_rem;
  logic [ACC_W-1:0] r_acc;
  logic             r_wrap;
  logic [ACC_W-1:0] w_prod;
  logic             w_cmd_hs;
  logic             w_op_hs;

  assign w_cmd_hs = cmd_valid & cmd_ready;
  assign w_op_hs  = op_valid & op_ready;
  assign w_prod   = ACC_W'(r_a) * ACC_W'(r_b);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  // Ready/busy decode from state alone, so no valid input reaches them combinationally.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = (cmd_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        op_ready = 1'b1;
        if (op_valid && r_rem == CNT_W'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Stage 1 captures operands; stage 2 applies the term on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s1_vld <= 1'b0;
      r_rem    <= '0;
      r_acc    <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_s1_vld <= w_op_hs;
      if (w_op_hs) begin
        r_a   <= op_a;
        r_b   <= op_b;
        r_rem <= r_rem - CNT_W'(1);
      end
      if (w_cmd_hs) begin
        r_acc  <= cmd_init;
        r_wrap <= 1'b0;
        r_rem  <= cmd_len;
      end else if (r_s1_vld) begin
        // Borrow out of the modulo subtraction is exactly product > accumulator.
        r_acc  <= r_acc - w_prod;
        r_wrap <= r_wrap | (w_prod > r_acc);
      end
    end
  end

  assign res_data = r_acc;
  assign res_wrap = r_wrap;

endmodule

// File: tb/tb_mac_sub_job_sequencer.sv
// Randomized self-checking bench for mac_sub_job_sequencer against an arithmetic job model.
module tb_mac_sub_job_sequencer;

  localparam int          A_W   = 20;
  localparam int          B_W   = 18;
  localparam int          ACC_W = 38;
  localparam int          CNT_W = 8;
  localparam logic [63:0] MASK  = (64'd1 << ACC_W) - 64'd1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len = '0;
  logic [ACC_W-1:0] cmd_init = '0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [A_W-1:0]   op_a = '0;
  logic [B_W-1:0]   op_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [ACC_W-1:0] res_data;
  logic             res_wrap;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [A_W-1:0] mem_a[256];
  logic [B_W-1:0] mem_b[256];

  logic [ACC_W-1:0] obs_data;
  logic             obs_wrap;

  always #5 clk = ~clk;

  mac_sub_job_sequencer #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_init(cmd_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_wrap(res_wrap),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Job result from plain arithmetic: subtract each product modulo 2^ACC_W, note any borrow.
  task automatic model(input logic [ACC_W-1:0] init, input int len,
                       output logic [ACC_W-1:0] d, output logic w);
    logic [63:0] acc;
    logic [63:0] p;
    acc = 64'(init);
    w   = 1'b0;
    for (int i = 0; i < len; i++) begin
      p = 64'(mem_a[i]) * 64'(mem_b[i]);
      if (p > acc) w = 1'b1;
      acc = (acc - p) & MASK;
    end
    d = acc[ACC_W-1:0];
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      mem_a[i] = A_W'($urandom);
      mem_b[i] = B_W'($urandom);
    end
  endtask

  // Runs one job; gaps toggles op_valid and offers a stray command while busy.
  task automatic run_job(input string tag, input logic [ACC_W-1:0] init, input int len,
                         input bit gaps, input int hold);
    logic [ACC_W-1:0] ed;
    logic             ew;
    int               hs;
    int               cyc;
    int               lat;
    bit               tog;
    bit               v;
    hs  = 0;
    cyc = 0;
    lat = -1;
    tog = 1'b1;
    model(init, len, ed, ew);
    @(negedge clk);
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(len);
    cmd_init  = init;
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cmd_valid = gaps;
    cmd_init  = ~init;
    cmd_len   = CNT_W'(3);
    cyc = 0;
    while (!res_valid && cyc < 2000) begin
      v   = gaps ? tog : 1'b1;
      tog = ~tog;
      op_valid = v;
      op_a = (hs < len) ? mem_a[hs] : 20'hABCDE;
      op_b = (hs < len) ? mem_b[hs] : 18'h2BCDE;
      if (v && op_ready) begin
        hs++;
        if (hs == len) lat = 0;
      end
      @(negedge clk);
      cyc++;
      if (lat >= 0) lat++;
      check({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    check({tag, "_res_valid_timeout"}, 64'(res_valid), 64'd1);
    check({tag, "_op_hs_count"}, 64'(hs), 64'(len));
    if (len > 0) check({tag, "_latency"}, 64'(lat), 64'd2);
    op_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(res_data), 64'(ed));
      @(negedge clk);
    end
    check({tag, "_data"}, 64'(res_data), 64'(ed));
    check({tag, "_wrap"}, 64'(res_wrap), 64'(ew));
    obs_data  = res_data;
    obs_wrap  = res_wrap;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_after_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_after_idle"}, 64'({busy, cmd_ready}), 64'b01);
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_op_ready", 64'(op_ready), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_wrap", 64'(res_wrap), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Reset in the middle of a 5-term job after two operands.
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(5);
    cmd_init  = 38'd12345;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("mid_op_ready", 64'(op_ready), 64'd1);
      op_valid = 1'b1;
      op_a     = 20'(i + 3);
      op_b     = 18'(i + 7);
      @(negedge clk);
    end
    op_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_acc", 64'(res_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_state", 64'({res_valid, busy, cmd_ready, op_ready}), 64'b0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_result", 64'(res_valid), 64'd0);
    end

    mem_a[0] = 20'h7FFFF;
    mem_b[0] = 18'h1FFFF;
    run_job("after_rst", 38'd0, 1, 1'b0, 0);
    check("after_rst_lit", 64'({obs_wrap, obs_data}), {25'd0, 1'b1, 38'd206159085567});

    mem_a[0] = 20'hFFFFF;
    mem_b[0] = 18'h3FFFF;
    run_job("max_zero", 38'd0, 1, 1'b0, 0);
    check("max_zero_lit", 64'({obs_wrap, obs_data}), {25'd0, 1'b1, 38'd1310719});
    run_job("max_full", {ACC_W{1'b1}}, 1, 1'b0, 0);
    check("max_full_lit", 64'({obs_wrap, obs_data}), {25'd0, 1'b0, 38'd1310718});

    run_job("len0", 38'd1000, 0, 1'b0, 0);
    check("len0_lit", 64'({obs_wrap, obs_data}), {25'd0, 1'b0, 38'd1000});

    mem_a[0] = 20'h80000; mem_b[0] = 18'h20000;
    mem_a[1] = 20'd2;     mem_b[1] = 18'd3;
    mem_a[2] = 20'd5;     mem_b[2] = 18'd7;
    run_job("len3_b2b", {ACC_W{1'b1}}, 3, 1'b0, 0);
    check("len3_b2b_lit", 64'({obs_wrap, obs_data}), {25'd0, 1'b0, 38'd206158430166});
    run_job("len3_gaps", {ACC_W{1'b1}}, 3, 1'b1, 4);
    check("len3_gaps_lit", 64'({obs_wrap, obs_data}), {25'd0, 1'b0, 38'd206158430166});

    for (int j = 0; j < 6; j++) begin
      int len;
      len = $urandom_range(1, 12);
      fill_random(len);
      run_job("rand_small", ACC_W'({$urandom, $urandom}), len, 1'(j % 2), j % 3);
    end

    fill_random(255);
    run_job("len255_b2b", ACC_W'({$urandom, $urandom}), 255, 1'b0, 0);
    fill_random(255);
    run_job("len255_gaps", ACC_W'({$urandom, $urandom}), 255, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
